// File: rtl/vermibus_arbiter.sv
// -----------------------------------------------------------------------------
// vermibus_arbiter
//   Round-robin arbiter sharing one Vermibus target between NUM_REQ requesters.
//   One requester is granted at a time for one complete valid/ready transaction.
//   While granted, its request is forwarded combinationally to the target and the
//   target response is returned.
//
// Parameters
//   NUM_REQ        number of requesters (2..8)
//   TIMEOUT_CYCLES watchdog limit in cycles (only with VERMIBUS_ARBITER_TIMEOUT_EN)
//
// Optional feature macro: VERMIBUS_ARBITER_TIMEOUT_EN
//   When defined, a stalled transaction is force-completed after TIMEOUT_CYCLES
//   BUSY cycles (req_ready forced, req_rdata = 0) and timeout_err latches until
//   reset. When undefined, timeout_err is tied low and BUSY waits indefinitely.
//
// Ports
//   clk, reset                       clock, asynchronous active-low reset
//   req_valid/address/wstrobe/wdata  flat requester request vectors (slice i)
//   req_ready                        per-requester ready (only granted index)
//   req_rdata                        read data broadcast to all requesters
//   tgt_valid/address/wstrobe/wdata  request forwarded to the target
//   tgt_ready, tgt_rdata             target response
//   grant                            registered one-hot grant, zero when idle
//   timeout_err                      sticky watchdog error flag
// -----------------------------------------------------------------------------
module vermibus_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_address,
  input  logic [NUM_REQ*4-1:0]  req_wstrobe,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           req_rdata,
  output logic                  tgt_valid,
  output logic [31:0]           tgt_address,
  output logic [3:0]            tgt_wstrobe,
  output logic [31:0]           tgt_wdata,
  input  logic                  tgt_ready,
  input  logic [31:0]           tgt_rdata,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  timeout_err
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("vermibus_arbiter: unsupported parameter values");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_ptr;    // last granted index; equals the granted index in BUSY

  logic               w_busy;
  logic               w_cur_valid;
  logic               w_force;
  logic               w_done;
  logic               w_load;
  logic [NUM_REQ-1:0] w_mask;
  logic               w_hit;
  logic [IW-1:0]      w_sel;
  logic [NUM_REQ-1:0] w_sel_oh;
  int unsigned        w_idx;

  assign w_busy      = (r_state == BUSY);
  assign w_cur_valid = w_busy && req_valid[r_ptr];

  // Because r_ptr tracks the grant, the scan always starts at r_ptr+1, both for
  // fresh arbitration in IDLE and for re-arbitration on completion in BUSY.
  assign w_mask = w_busy ? (req_valid & ~r_grant) : req_valid;

  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_hit && w_mask[w_idx[IW-1:0]]) begin
        w_hit = 1'b1;
        w_sel = w_idx[IW-1:0];
      end
    end
  end

  assign w_sel_oh = NUM_REQ'(1) << w_sel;
  assign w_done   = w_cur_valid && (tgt_ready || w_force);
  assign w_load   = w_hit && (!w_busy || w_done);

  assign tgt_valid   = w_cur_valid;
  assign tgt_address = w_busy ? req_address[{r_ptr, 5'b0} +: 32] : '0;
  assign tgt_wstrobe = w_busy ? req_wstrobe[{r_ptr, 2'b0} +: 4]  : '0;
  assign tgt_wdata   = w_busy ? req_wdata[{r_ptr, 5'b0} +: 32]   : '0;

  assign req_ready = r_grant & {NUM_REQ{tgt_ready | w_force}};
  assign req_rdata = w_force ? '0 : tgt_rdata;
  assign grant     = r_grant;

`ifdef VERMIBUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_cnt;
  logic          r_terr;

  assign w_force     = w_cur_valid && !tgt_ready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_terr;
`else
  assign w_force     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= IW'(NUM_REQ - 1);
`ifdef VERMIBUS_ARBITER_TIMEOUT_EN
      r_cnt   <= '0;
      r_terr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state <= BUSY;
            r_grant <= w_sel_oh;
            r_ptr   <= w_sel;
          end
        end
        BUSY: begin
          if (w_done) begin
            if (w_hit) begin
              r_grant <= w_sel_oh;
              r_ptr   <= w_sel;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
            end
          end else if (!w_cur_valid) begin
            // requester withdrew without completing: release the target
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
`ifdef VERMIBUS_ARBITER_TIMEOUT_EN
      if (w_load)
        r_cnt <= '0;
      else if (w_cur_valid && !tgt_ready)
        r_cnt <= r_cnt + 1'b1;
      if (w_force)
        r_terr <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_vermibus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vermibus_arbiter
//   Scoreboard bench for vermibus_arbiter (NUM_REQ = 2). Each issued transaction
//   pushes its expected target-side view and response onto a queue; the monitor
//   pops the matching entry when the requester sees valid && ready. The target
//   model answers after a programmable delay with rdata = address ^ 0xDEADBEFF.
// -----------------------------------------------------------------------------
module tb_vermibus_arbiter;

  localparam int unsigned N = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*32-1:0]   req_address;
  logic [N*4-1:0]    req_wstrobe;
  logic [N*32-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [31:0]       req_rdata;
  logic              tgt_valid;
  logic [31:0]       tgt_address;
  logic [3:0]        tgt_wstrobe;
  logic [31:0]       tgt_wdata;
  logic              tgt_ready;
  logic [31:0]       tgt_rdata;
  logic [N-1:0]      grant;
  logic              timeout_err;

  logic              rv[N];
  logic [31:0]       ra[N];
  logic [3:0]        rs[N];
  logic [31:0]       rd[N];

  always #5 clk = ~clk;

  always_comb begin
    req_valid   = '0;
    req_address = '0;
    req_wstrobe = '0;
    req_wdata   = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = rv[i];
      req_address[32*i +: 32] = ra[i];
      req_wstrobe[4*i +: 4]   = rs[i];
      req_wdata[32*i +: 32]   = rd[i];
    end
  end

  vermibus_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_address (req_address),
    .req_wstrobe (req_wstrobe),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .req_rdata   (req_rdata),
    .tgt_valid   (tgt_valid),
    .tgt_address (tgt_address),
    .tgt_wstrobe (tgt_wstrobe),
    .tgt_wdata   (tgt_wdata),
    .tgt_ready   (tgt_ready),
    .tgt_rdata   (tgt_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   log_r[$];
  int   log_c[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tgt_delay = 0;
  int wait_cnt  = 0;
  bit hs_last   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] resp(input logic [31:0] a);
    return a ^ 32'hDEAD_BEFF;
  endfunction

  // Target model: ready after tgt_delay waiting cycles of tgt_valid.
  initial begin
    tgt_ready = 1'b0;
    tgt_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!tgt_valid || hs_last) wait_cnt = 0;
      if (tgt_valid && wait_cnt >= tgt_delay) begin
        tgt_ready = 1'b1;
        tgt_rdata = resp(tgt_address);
      end else begin
        tgt_ready = 1'b0;
        tgt_rdata = 32'h0BAD_0BAD;
        if (tgt_valid) wait_cnt++;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on each requester handshake.
  always @(negedge clk) begin
    int found;
    cyc++;
    hs_last = tgt_valid && tgt_ready;
    if (reset) begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("ready_only_granted", 32'(req_ready & ~grant), 32'd0);
      for (int r = 0; r < N; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          found = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (found < 0 && exp_q[k].r == r) found = k;
          check($sformatf("sb_expected_r%0d", r), 32'(found >= 0), 32'd1);
          if (found >= 0) begin
            check($sformatf("tgt_addr_r%0d", r),   tgt_address, exp_q[found].a);
            check($sformatf("tgt_wstrb_r%0d", r),  32'(tgt_wstrobe), 32'(exp_q[found].s));
            check($sformatf("tgt_wdata_r%0d", r),  tgt_wdata, exp_q[found].d);
            check($sformatf("req_rdata_r%0d", r),  req_rdata, exp_q[found].rdata);
            exp_q.delete(found);
          end
          log_r.push_back(r);
          log_c.push_back(cyc);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one transaction on requester r and wait for its handshake; leaves
  // valid high so callers can chain back-to-back transactions.
  task automatic issue(input int r, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input bit forced);
    txn_t t;
    bit   done;
    t.r = r; t.a = a; t.s = s; t.d = d;
    t.rdata = forced ? 32'h0 : resp(a);
    exp_q.push_back(t);
    rv[r] = 1'b1; ra[r] = a; rs[r] = s; rd[r] = d;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_valid[r] && req_ready[r]) done = 1'b1;
      next_cycle();
    end
    if (!done) begin
      check($sformatf("handshake_timeout_r%0d", r), 32'd0, 32'd1);
      rv[r] = 1'b0;
    end
  endtask

  task automatic clear_logs();
    log_r.delete();
    log_c.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rs[i] = '0; rd[i] = '0;
    end
    repeat (3) next_cycle();

    // Reset state
    check("rst_grant",     32'(grant), 32'd0);
    check("rst_tgt_valid", 32'(tgt_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tgt_addr",  tgt_address, 32'd0);
    check("rst_to_err",    32'(timeout_err), 32'd0);
    reset = 1'b1;
    repeat (2) next_cycle();

    // Single read, target ready after 2 wait cycles
    tgt_delay = 2;
    clear_logs();
    fork
      issue(0, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
      begin
        @(negedge clk);
        check("t1_idle_grant", 32'(grant), 32'd0);
        @(negedge clk);
        check("t1_grant",     32'(grant), 32'd1);
        check("t1_tgt_valid", 32'(tgt_valid), 32'd1);
        check("t1_tgt_addr",  tgt_address, 32'h0000_0010);
      end
    join
    rv[0] = 1'b0;
    @(negedge clk);
    check("t1_back_idle_grant", 32'(grant), 32'd0);
    check("t1_back_idle_valid", 32'(tgt_valid), 32'd0);
    next_cycle();
    check("t1_count", 32'(log_r.size()), 32'd1);

    // Both requesters continuously valid, target always ready.
    // Requester 0 was granted last, so requester 1 wins first.
    tgt_delay = 0;
    clear_logs();
    fork
      begin
        for (int k = 0; k < 3; k++) issue(0, 32'h100 + 32'(4*k), 4'h0, 32'h0, 1'b0);
        rv[0] = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) issue(1, 32'h200 + 32'(4*k), 4'h0, 32'h0, 1'b0);
        rv[1] = 1'b0;
      end
    join
    next_cycle();
    check("t2_count", 32'(log_r.size()), 32'd6);
    for (int k = 0; k < log_r.size(); k++)
      check($sformatf("t2_order_%0d", k), 32'(log_r[k]), 32'((k + 1) % 2));
    for (int k = 1; k < log_c.size(); k++)
      check($sformatf("t2_no_bubble_%0d", k), 32'(log_c[k] - log_c[k-1]), 32'd1);

    // Write from requester 1 while requester 0 is in a slow read
    tgt_delay = 3;
    clear_logs();
    fork
      begin
        issue(0, 32'h0000_0020, 4'h0, 32'h0, 1'b0);
        rv[0] = 1'b0;
      end
      begin
        next_cycle();
        issue(1, 32'h1000_0000, 4'hF, 32'h1234_5678, 1'b0);
        rv[1] = 1'b0;
      end
      begin
        next_cycle();
        repeat (2) begin
          @(negedge clk);
          check("t3_addr_hold",  tgt_address, 32'h0000_0020);
          check("t3_wstrb_hold", 32'(tgt_wstrobe), 32'd0);
          check("t3_r1_wait",    32'(req_ready[1]), 32'd0);
          check("t3_grant_r0",   32'(grant), 32'd1);
        end
      end
    join
    next_cycle();
    check("t3_count", 32'(log_r.size()), 32'd2);
    if (log_r.size() == 2) begin
      check("t3_first",  32'(log_r[0]), 32'd0);
      check("t3_second", 32'(log_r[1]), 32'd1);
    end

    // Single requester, three back-to-back reads: one idle cycle between grants
    tgt_delay = 0;
    clear_logs();
    for (int k = 0; k < 3; k++) issue(0, 32'h300 + 32'(4*k), 4'h0, 32'h0, 1'b0);
    rv[0] = 1'b0;
    next_cycle();
    check("t4_count", 32'(log_r.size()), 32'd3);
    for (int k = 1; k < log_c.size(); k++)
      check($sformatf("t4_one_idle_%0d", k), 32'(log_c[k] - log_c[k-1]), 32'd2);

    // Reset while BUSY with the target stalled
    tgt_delay = 1000;
    rv[0] = 1'b1; ra[0] = 32'h0000_0040; rs[0] = '0; rd[0] = '0;
    repeat (3) next_cycle();
    check("t5_busy_grant", 32'(grant), 32'd1);
    check("t5_busy_valid", 32'(tgt_valid), 32'd1);
    reset = 1'b0;
    #2;
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_valid", 32'(tgt_valid), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    rv[0] = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b1;
    tgt_delay = 0;
    clear_logs();
    fork
      begin issue(1, 32'h0000_0500, 4'h3, 32'hCAFE_0001, 1'b0); rv[1] = 1'b0; end
      begin issue(0, 32'h0000_0600, 4'h0, 32'h0, 1'b0);        rv[0] = 1'b0; end
    join
    next_cycle();
    check("t5_count", 32'(log_r.size()), 32'd2);
    if (log_r.size() == 2)
      check("t5_r0_first", 32'(log_r[0]), 32'd0);

`ifdef VERMIBUS_ARBITER_TIMEOUT_EN
    // Watchdog with TIMEOUT_CYCLES = 8, target never ready
    tgt_delay = 1000;
    clear_logs();
    check("t6_err_before", 32'(timeout_err), 32'd0);
    start = cyc;
    issue(0, 32'h0000_0050, 4'h0, 32'h0, 1'b1);
    rv[0] = 1'b0;
    check("t6_count", 32'(log_c.size()), 32'd1);
    if (log_c.size() == 1)
      check("t6_forced_cycle", 32'(log_c[0]), 32'(start + 9));
    check("t6_err_set", 32'(timeout_err), 32'd1);
    tgt_delay = 0;
    issue(0, 32'h0000_0054, 4'h0, 32'h0, 1'b0);
    rv[0] = 1'b0;
    next_cycle();
    check("t6_next_served", 32'(log_c.size()), 32'd2);
    check("t6_err_sticky", 32'(timeout_err), 32'd1);
`else
    start = cyc;
    check("to_err_tied_low", 32'(timeout_err), 32'd0);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
